// File: rtl/song_addr_calc_if.sv
// Control/address bundle between the audio front end and song_addr_calc.
// The master drives the sample strobe and song commands; the slave returns the ZBT addresses and status.
interface song_addr_calc_if #(
    parameter int ADDR_W    = 19,
    parameter int SONG_BITS = 3
);
    logic                 ready;
    logic                 start_song;
    logic [SONG_BITS:0]   song_choice;
    logic                 record_mode;
    logic                 pause_song;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic                 song_done;
    logic                 busy;

    modport master (
        output ready, start_song, song_choice, record_mode, pause_song,
        input  addr0, addr1, song_done, busy
    );

    modport slave (
        input  ready, start_song, song_choice, record_mode, pause_song,
        output addr0, addr1, song_done, busy
    );
endinterface

// File: rtl/song_addr_calc.sv
// ZBT address generator and per-song length table for record/playback, three samples per word.
// Optional build macro LOOP_PLAYBACK_EN: playback wraps to the start of the song instead of finishing.
module song_addr_calc #(
    parameter int ADDR_W    = 19,
    parameter int SONG_BITS = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    song_addr_calc_if.slave    bus
);
    localparam int REGION_W = ADDR_W - SONG_BITS;
    localparam int NUM_SONG = 2 ** (SONG_BITS + 1);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY, DONE} state_t;

    state_t                 state;
    logic                   bank;
    logic [SONG_BITS-1:0]   song;
    logic [REGION_W-1:0]    offset;
    logic [1:0]             cnt3;
    logic                   done;
    logic [REGION_W:0]      len [NUM_SONG];

    logic [SONG_BITS:0]     sel;
    logic [SONG_BITS:0]     choice;
    logic [REGION_W:0]      offset_inc;
    logic                   advance;
    logic [ADDR_W-1:0]      song_addr;

    assign sel        = {bank, song};
    assign choice     = bus.song_choice;
    assign offset_inc = {1'b0, offset} + 1'b1;
    assign advance    = bus.ready & ~bus.pause_song & ~done & ~bus.start_song &
                        ((state == RECORD) || (state == PLAY));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            bank   <= 1'b0;
            song   <= '0;
            offset <= '0;
            cnt3   <= 2'd0;
            done   <= 1'b0;
            for (int i = 0; i < NUM_SONG; i++) begin
                len[i] <= '0;
            end
        end else if (bus.start_song) begin
            offset <= '0;
            cnt3   <= 2'd0;
            bank   <= choice[SONG_BITS];
            song   <= choice[SONG_BITS-1:0];
            if (bus.record_mode) begin
                state       <= RECORD;
                done        <= 1'b0;
                len[choice] <= '0;
            end else if (len[choice] == '0) begin
                // nothing recorded: finish immediately so the player does not stall
                state <= DONE;
                done  <= 1'b1;
            end else begin
                state <= PLAY;
                done  <= 1'b0;
            end
        end else if (advance) begin
            if (cnt3 != 2'd2) begin
                cnt3 <= cnt3 + 2'd1;
            end else begin
                cnt3 <= 2'd0;
                if (state == RECORD) begin
                    // offset_inc carries into the top bit when the region is full
                    len[sel] <= offset_inc;
                    if (&offset) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        offset <= offset_inc[REGION_W-1:0];
                    end
                end else if (offset_inc == len[sel]) begin
`ifdef LOOP_PLAYBACK_EN
                    offset <= '0;
`else
                    state <= DONE;
                    done  <= 1'b1;
`endif
                end else begin
                    offset <= offset_inc[REGION_W-1:0];
                end
            end
        end
    end

    assign song_addr     = {song, offset};
    assign bus.addr0     = ((state != IDLE) && !bank) ? song_addr : '0;
    assign bus.addr1     = ((state != IDLE) &&  bank) ? song_addr : '0;
    assign bus.song_done = done;
    assign bus.busy      = (state == RECORD) || (state == PLAY);
endmodule

// File: tb/tb_song_addr_calc.sv
// Directed bench for song_addr_calc: record, playback, pause, collision, reset, empty song, region full.
// A second, narrow instance makes the region-full case short.
module tb_song_addr_calc;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    song_addr_calc_if #(.ADDR_W(19), .SONG_BITS(3)) bus ();
    song_addr_calc_if #(.ADDR_W(9),  .SONG_BITS(3)) sbus ();

    song_addr_calc #(.ADDR_W(19), .SONG_BITS(3)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    song_addr_calc #(.ADDR_W(9), .SONG_BITS(3)) u_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic start(input logic [3:0] choice, input logic rec);
        @(negedge clk);
        bus.song_choice = choice;
        bus.record_mode = rec;
        bus.start_song  = 1'b1;
        @(negedge clk);
        bus.start_song  = 1'b0;
        bus.ready       = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.ready = 1'b1;
            @(negedge clk);
            bus.ready = 1'b0;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        bus.ready = 1'b0;  bus.start_song = 1'b0;  bus.song_choice = 4'd0;
        bus.record_mode = 1'b0;  bus.pause_song = 1'b0;
        sbus.ready = 1'b0; sbus.start_song = 1'b0; sbus.song_choice = 4'd0;
        sbus.record_mode = 1'b0; sbus.pause_song = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_addr0", 32'(bus.addr0), 32'h0);
        check("reset_addr1", 32'(bus.addr1), 32'h0);
        check("reset_done",  32'(bus.song_done), 32'h0);
        check("reset_busy",  32'(bus.busy), 32'h0);
        reset_n = 1'b1;

        // record song 13: three words
        start(4'b1101, 1'b1);
        check("rec_start_addr1", 32'(bus.addr1), 32'h50000);
        check("rec_start_busy",  32'(bus.busy), 32'h1);
        pulses(2);
        check("rec_p2_addr1", 32'(bus.addr1), 32'h50000);
        pulses(1);
        check("rec_p3_addr1", 32'(bus.addr1), 32'h50001);
        pulses(3);
        check("rec_p6_addr1", 32'(bus.addr1), 32'h50002);
        pulses(3);
        check("rec_p9_addr1", 32'(bus.addr1), 32'h50003);
        check("rec_p9_addr0", 32'(bus.addr0), 32'h0);
        check("rec_p9_done",  32'(bus.song_done), 32'h0);

        // play it back
        start(4'b1101, 1'b0);
        check("play_start_addr1", 32'(bus.addr1), 32'h50000);
        check("play_start_busy",  32'(bus.busy), 32'h1);
        pulses(3);
        check("play_p3_addr1", 32'(bus.addr1), 32'h50001);
        bus.song_choice = 4'b0000;
        pulses(3);
        check("play_p6_addr1", 32'(bus.addr1), 32'h50002);
        check("play_p6_addr0", 32'(bus.addr0), 32'h0);
        pulses(3);
`ifdef LOOP_PLAYBACK_EN
        check("loop_p9_addr1", 32'(bus.addr1), 32'h50000);
        check("loop_p9_done",  32'(bus.song_done), 32'h0);
        pulses(3);
        check("loop_p12_addr1", 32'(bus.addr1), 32'h50001);
        pulses(3);
        check("loop_p15_addr1", 32'(bus.addr1), 32'h50002);
        pulses(3);
        check("loop_p18_addr1", 32'(bus.addr1), 32'h50000);
`else
        check("play_p9_addr1", 32'(bus.addr1), 32'h50002);
        check("play_p9_done",  32'(bus.song_done), 32'h1);
        check("play_p9_busy",  32'(bus.busy), 32'h0);
        pulses(1);
        check("play_p10_addr1", 32'(bus.addr1), 32'h50002);
        check("play_p10_done",  32'(bus.song_done), 32'h1);
`endif

        // pause, then start_song coincident with ready
        start(4'b1101, 1'b0);
        pulses(2);
        bus.pause_song = 1'b1;
        pulses(5);
        check("pause_addr1", 32'(bus.addr1), 32'h50000);
        bus.pause_song = 1'b0;
        @(negedge clk);
        bus.ready = 1'b1;
        start(4'b1101, 1'b0);
        check("coll_addr1", 32'(bus.addr1), 32'h50000);
        pulses(2);
        check("coll_p2_addr1", 32'(bus.addr1), 32'h50000);
        pulses(1);
        check("coll_p3_addr1", 32'(bus.addr1), 32'h50001);

        // asynchronous reset in mid-play
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_addr1", 32'(bus.addr1), 32'h0);
        check("midrst_busy",  32'(bus.busy), 32'h0);
        check("midrst_done",  32'(bus.song_done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        start(4'b1101, 1'b0);
        check("postrst_done", 32'(bus.song_done), 32'h1);
        check("postrst_busy", 32'(bus.busy), 32'h0);

        // empty song in bank 0
        start(4'b0010, 1'b0);
        check("empty_done",  32'(bus.song_done), 32'h1);
        check("empty_addr1", 32'(bus.addr1), 32'h0);

        // region full on the narrow instance: 64 words x 3 samples
        @(negedge clk);
        sbus.song_choice = 4'b0011;
        sbus.record_mode = 1'b1;
        sbus.start_song  = 1'b1;
        @(negedge clk);
        sbus.start_song  = 1'b0;
        sbus.ready       = 1'b1;
        repeat (191) @(negedge clk);
        check("full_191_addr0", 32'(sbus.addr0), 32'h0FF);
        check("full_191_done",  32'(sbus.song_done), 32'h0);
        @(negedge clk);
        check("full_192_done",  32'(sbus.song_done), 32'h1);
        check("full_192_addr0", 32'(sbus.addr0), 32'h0FF);
        check("full_192_busy",  32'(sbus.busy), 32'h0);
        repeat (3) @(negedge clk);
        sbus.ready = 1'b0;
        check("full_hold_addr0", 32'(sbus.addr0), 32'h0FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/song_addr_calc.md
# song_addr_calc

Address generator and song-length bookkeeper on the ZBT side of the audio path. Runs alongside the memory processor: it mirrors that block's three-samples-per-word cadence to drive ZBT bank addresses, records each song's length while recording, and raises `song_done` when playback reaches the recorded end or a recording fills its region. Each of the two banks holds 8 songs in equal fixed regions.

## Interface

Parameters:
- `ADDR_W`, default 19: ZBT word address width (512K × 36 per bank).
- `SONG_BITS`, default 3: song-select bits per bank. The region width is `REGION_W = ADDR_W - SONG_BITS`, which is 16.

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ready`, input, 1: one-cycle pulse when an AC97 sample is available.
- `start_song`, input, 1: one-cycle pulse; (re)starts the selected song.
- `song_choice`, input, 4: bit 3 selects the bank (0 or 1); bits 2:0 select the song within that bank.
- `record_mode`, input, 1: sampled on `start_song`. 1 means record, 0 means play.
- `pause_song`, input, 1: level; freezes all progress.
- `addr0`, output, `ADDR_W`: ZBT bank 0 address.
- `addr1`, output, `ADDR_W`: ZBT bank 1 address.
- `song_done`, output, 1: registered; end of song or region full.
- `busy`, output, 1: high in the RECORD and PLAY states.

## Operation

- States are IDLE, RECORD, PLAY and DONE.
- Latched on `start_song`: `bank` (from `song_choice[3]`), `song` (from `song_choice[2:0]`) and `rec` (from `record_mode`).
- `offset` is a `REGION_W`-bit word offset. `cnt3` is a 2-bit sample counter that counts 0, 1, 2, 0.
- `start_song` in any state:
  - clears `offset`, `cnt3` and `song_done`;
  - goes to RECORD if `record_mode` is 1, else to PLAY;
  - when entering RECORD, clears `len[bank,song]` to 0;
  - when entering PLAY with `len[bank,song]` equal to 0, goes straight to DONE and sets `song_done` on the next cycle.
- Advance condition: `ready & ~pause_song & ~song_done & ~start_song`, in RECORD or PLAY only.
  - On advance, `cnt3` increments.
  - When `cnt3` is 2, `cnt3` wraps to 0 and the word step runs.
- Word step in RECORD:
  - `offset` increments by 1;
  - `len[bank,song]` becomes `offset + 1` (width `REGION_W+1`).
  - If `offset` was all-ones, `offset` holds, `len` becomes 2^`REGION_W`, the block goes to DONE and `song_done` is set.
- Word step in PLAY:
  - if `offset + 1` equals `len[bank,song]`, `offset` holds, the block goes to DONE and `song_done` is set;
  - otherwise `offset` increments.
- Length table: 16 entries × (`REGION_W+1`) bits, held in registers. All entries clear on reset.
- Address outputs:
  - the selected bank's address is `{song, offset}`;
  - the other bank's address is 0.
- DONE holds the address and `song_done` until the next `start_song`. IDLE outputs are all 0.

## Timing

- Reset values: `addr0` = 0, `addr1` = 0, `song_done` = 0, `busy` = 0, state = IDLE, `len[*]` = 0.
- Reset takes effect immediately while `reset_n` is low, including mid-song. After reset, a new `start_song` is required; the length table has been lost.
- Addresses are registered and change on the clock edge after the qualifying `ready`. This lines up with the memory processor latching the read word when its counter is 2.
- The ZBT read latency (2 cycles) is well under the spacing of `ready` pulses, so no extra pipelining is needed.
- `start_song` and `ready` in the same cycle: `start_song` wins and the `ready` is dropped.
- `pause_song` held high: `cnt3`, `offset` and `len` are frozen. Outputs hold.
- `song_done` rises one cycle after the final word step, and further `ready` pulses are ignored. For an empty song it rises one cycle after `start_song`.
- A `song_choice` change without `start_song` has no effect.

## Configuration

- `LOOP_PLAYBACK_EN` defined: in PLAY, the end-of-song word step sets `offset` to 0 instead of entering DONE.
  - `song_done` never rises in PLAY, except for an empty song.
  - RECORD behaviour is unchanged.
- `LOOP_PLAYBACK_EN` undefined: playback stops at the end in DONE, as described in Operation.

## Test plan

- **Reset:** hold `reset_n` low mid-play → `addr0` = `addr1` = 0, `song_done` = 0, `busy` = 0 asynchronously. A PLAY of any song after release gives `song_done` = 1 one cycle after `start_song` (the table was cleared).
- **Record:** `start_song` with `song_choice` = 4'b1101 and `record_mode` = 1, then 9 `ready` pulses → `addr1` steps 0x50000, 0x50001, 0x50002, 0x50003 after pulses 3, 6 and 9. `addr0` stays 0. `len[1,5]` = 3.
- **Playback end:** `start_song` with `song_choice` = 4'b1101 and `record_mode` = 0, then 9 `ready` pulses → `addr1` = 0x50001 after pulse 3 and 0x50002 after pulse 6. After pulse 9 `addr1` holds 0x50002 and `song_done` = 1. A 10th pulse changes nothing.
- **Pause and collision:** 2 `ready` pulses, then 5 pulses with `pause_song` = 1, then `ready` coincident with `start_song` → the address is unchanged during the pause, and the coincident `start_song` resets the offset to 0 with `cnt3` = 0.
- **Empty song and region full:**
  - PLAY with `song_choice` = 4'b0010 → `song_done` = 1 one cycle after `start_song`.
  - RECORD with 3 × 65536 pulses → `song_done` on the last pulse, `addr` = {song, 0xFFFF}.
- **`LOOP_PLAYBACK_EN` build:** replay song 13 (3 words, `song_choice` = 4'b1101) → after pulse 9 `addr1` = 0x50000 and `song_done` = 0, and the address keeps cycling through 0x50000, 0x50001, 0x50002.
